// File: rtl/ldm_stm_seq.sv
// LDM/STM block-transfer sequencer: walks the register list one word per cycle, then optional base writeback.
// Optional abort support is built when LDM_STM_ABORT_EN is defined (adds data_abort / aborted).
module ldm_stm_seq #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              load,
    input  logic              p_bit,
    input  logic              u_bit,
    input  logic              w_bit,
    input  logic [3:0]        base_rn,
    input  logic [15:0]       reg_list,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [DATA_W-1:0] rd_data,
    input  logic [DATA_W-1:0] mem_data_out,
`ifdef LDM_STM_ABORT_EN
    input  logic              data_abort,
    output logic              aborted,
`endif
    output logic              busy,
    output logic              done,
    output logic [3:0]        reg_sel,
    output logic              rd_we,
    output logic [DATA_W-1:0] rd_in,
    output logic [3:0]        write_rd,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data_in,
    output logic              mem_write_en
);
    typedef enum logic [2:0] {S_IDLE, S_CALC, S_XFER, S_WB, S_DONE} state_t;

    localparam logic [ADDR_W-1:0] WORD       = ADDR_W'(4);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

    state_t            state_q;
    logic              load_q, p_q, u_q, w_q, rn_in_list_q;
    logic [3:0]        base_rn_q;
    logic [15:0]       list_q;
    logic [ADDR_W-1:0] base_q, addr_q, final_q;
    logic              busy_q, done_q, rd_we_q, mem_we_q;
    logic [3:0]        reg_sel_q, write_rd_q;
    logic [ADDR_W-1:0] mem_addr_q;

    logic [4:0]        n_d;
    logic [ADDR_W-1:0] four_n_d, first_d, final_d;
    logic [3:0]        low_idx_d;
    logic [15:0]       list_next_d;
    logic              abort_now;

    always_comb begin
        n_d       = 5'd0;
        low_idx_d = 4'd0;
        for (int i = 0; i < 16; i++) n_d = n_d + 5'(list_q[i]);
        for (int i = 15; i >= 0; i--) if (list_q[i]) low_idx_d = 4'(i);
        list_next_d = list_q & (list_q - 16'd1);
        four_n_d    = {{(ADDR_W-7){1'b0}}, n_d, 2'b00};
        final_d     = u_q ? (base_q + four_n_d) : (base_q - four_n_d);
        case ({p_q, u_q})
            2'b01:   first_d = base_q;
            2'b11:   first_d = base_q + WORD;
            2'b00:   first_d = base_q - four_n_d + WORD;
            default: first_d = base_q - four_n_d;
        endcase
    end

`ifdef LDM_STM_ABORT_EN
    logic aborted_q;
    assign abort_now = data_abort & (state_q == S_XFER);
    // An aborted XFER cycle always goes straight to DONE, so the flag lines up with done.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) aborted_q <= 1'b0;
        else      aborted_q <= abort_now;
    end
    assign aborted = aborted_q;
`else
    assign abort_now = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            load_q       <= 1'b0;
            p_q          <= 1'b0;
            u_q          <= 1'b0;
            w_q          <= 1'b0;
            rn_in_list_q <= 1'b0;
            base_rn_q    <= 4'd0;
            list_q       <= 16'd0;
            base_q       <= '0;
            addr_q       <= '0;
            final_q      <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            rd_we_q      <= 1'b0;
            mem_we_q     <= 1'b0;
            reg_sel_q    <= 4'd0;
            write_rd_q   <= 4'd0;
            mem_addr_q   <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        load_q       <= load;
                        p_q          <= p_bit;
                        u_q          <= u_bit;
                        w_q          <= w_bit;
                        base_rn_q    <= base_rn;
                        list_q       <= reg_list;
                        base_q       <= base_addr;
                        rn_in_list_q <= reg_list[base_rn];
                        busy_q       <= 1'b1;
                        state_q      <= S_CALC;
                    end
                end
                S_CALC: begin
                    final_q <= final_d;
                    if (n_d == 5'd0) begin
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        reg_sel_q  <= low_idx_d;
                        write_rd_q <= low_idx_d;
                        mem_addr_q <= first_d & ALIGN_MASK;
                        addr_q     <= (first_d & ALIGN_MASK) + WORD;
                        rd_we_q    <= load_q;
                        mem_we_q   <= ~load_q;
                        list_q     <= list_next_d;
                        state_q    <= S_XFER;
                    end
                end
                S_XFER: begin
                    if (abort_now) begin
                        rd_we_q  <= 1'b0;
                        mem_we_q <= 1'b0;
                        done_q   <= 1'b1;
                        state_q  <= S_DONE;
                    end else if (list_q != 16'd0) begin
                        reg_sel_q  <= low_idx_d;
                        write_rd_q <= low_idx_d;
                        mem_addr_q <= addr_q;
                        addr_q     <= addr_q + WORD;
                        list_q     <= list_next_d;
                    end else begin
                        mem_we_q <= 1'b0;
                        // A loaded base register keeps the loaded value rather than the writeback.
                        if (w_q && !(load_q && rn_in_list_q)) begin
                            rd_we_q    <= 1'b1;
                            write_rd_q <= base_rn_q;
                            state_q    <= S_WB;
                        end else begin
                            rd_we_q <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end
                    end
                end
                S_WB: begin
                    rd_we_q <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= S_DONE;
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign reg_sel      = reg_sel_q;
    assign write_rd     = write_rd_q;
    assign mem_addr     = mem_addr_q;
    assign rd_we        = rd_we_q & ~abort_now;
    assign mem_write_en = mem_we_q & ~abort_now;
    assign rd_in        = (state_q == S_WB) ? DATA_W'(final_q) : (rd_we_q ? mem_data_out : '0);
    assign mem_data_in  = mem_we_q ? rd_data : '0;
endmodule
